// File: rtl/request_pending_latch.sv
// Sticky capture of request events ahead of the LSB-first priority encoder, with per-line lost-event counters.
// An event lands in pend on the sampling edge; pend_vec is combinational; no backpressure: invalid acks are dropped and flagged on ack_err.
module request_pending_latch #(
    parameter bit EDGE_DET  = 1'b1,
    parameter int OVF_CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             req_in,
    input  logic [3:0]             mask,
    output logic [3:0]             pend_vec,
    output logic                   pend_vld,
    input  logic [1:0]             pos_in,
    input  logic                   ack,
    output logic                   ack_err,
    output logic [4*OVF_CNT_W-1:0] ovf_cnt,
    input  logic                   ovf_clr
);

    logic [3:0]           pend;
    logic [3:0]           req_d;
    logic [3:0]           evt;
    logic [3:0]           clr;
    logic [3:0]           inc;
    logic                 ack_ok;
    logic [OVF_CNT_W-1:0] cnt [4];

    assign pend_vec = pend & mask;
    assign pend_vld = |pend_vec;

    assign evt    = EDGE_DET ? (req_in & ~req_d) : req_in;
    // Masked lines read as clear here, so an ack aimed at them is rejected.
    assign ack_ok = ack & pend_vld & pend_vec[pos_in];
    assign inc    = evt & pend & ~clr;

    always_comb begin
        clr = '0;
        if (ack_ok)
            clr[pos_in] = 1'b1;
    end

    always_comb begin
        ovf_cnt = '0;
        for (int i = 0; i < 4; i++)
            ovf_cnt[i*OVF_CNT_W +: OVF_CNT_W] = cnt[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            req_d   <= '0;
            ack_err <= 1'b0;
            for (int i = 0; i < 4; i++)
                cnt[i] <= '0;
        end else begin
            // A new event on the bit being acked survives the clear.
            pend    <= (pend & ~clr) | evt;
            req_d   <= req_in;
            ack_err <= ack & ~ack_ok;
            for (int i = 0; i < 4; i++) begin
                if (ovf_clr)
                    cnt[i] <= '0;
                else if (inc[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + OVF_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_request_pending_latch.sv
// Bench for request_pending_latch: table-driven vectors scored through a queue, plus level-mode and async-reset sequences.
module tb_request_pending_latch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_in, mask, pend_vec;
    logic        pend_vld, ack, ack_err, ovf_clr;
    logic [1:0]  pos_in;
    logic [15:0] ovf_cnt;

    logic [3:0]  req_l, vec_l4, vec_l2;
    logic        vld_l4, vld_l2, err_l4, err_l2, clr_l;
    logic [15:0] ovf_l4;
    logic [7:0]  ovf_l2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    request_pending_latch dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
        .pend_vec(pend_vec), .pend_vld(pend_vld), .pos_in(pos_in), .ack(ack),
        .ack_err(ack_err), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    request_pending_latch #(.EDGE_DET(1'b0), .OVF_CNT_W(4)) dut_l4 (
        .clk(clk), .rst_n(rst_n), .req_in(req_l), .mask(4'hF),
        .pend_vec(vec_l4), .pend_vld(vld_l4), .pos_in(2'd0), .ack(1'b0),
        .ack_err(err_l4), .ovf_cnt(ovf_l4), .ovf_clr(clr_l)
    );

    request_pending_latch #(.EDGE_DET(1'b0), .OVF_CNT_W(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .req_in(req_l), .mask(4'hF),
        .pend_vec(vec_l2), .pend_vld(vld_l2), .pos_in(2'd0), .ack(1'b0),
        .ack_err(err_l2), .ovf_cnt(ovf_l2), .ovf_clr(clr_l)
    );

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  mask;
        logic [1:0]  pos;
        logic        ack;
        logic        oclr;
        logic [3:0]  e_vec;
        logic        e_vld;
        logic        e_err;
        logic [15:0] e_ovf;
    } vec_t;

    typedef struct packed {
        int          idx;
        logic [3:0]  vec;
        logic        vld;
        logic        err;
        logic [15:0] ovf;
    } exp_t;

    localparam int NV = 32;
    vec_t tbl [NV];
    exp_t sb [$];
    exp_t got;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] m, input logic [1:0] p,
                                input logic a, input logic c, input logic [3:0] ev,
                                input logic vl, input logic er, input logic [15:0] ov);
        vec_t v;
        v.req = r; v.mask = m; v.pos = p; v.ack = a; v.oclr = c;
        v.e_vec = ev; v.e_vld = vl; v.e_err = er; v.e_ovf = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input int i);
        exp_t x;
        @(negedge clk);
        #1;
        req_in  = tbl[i].req;
        mask    = tbl[i].mask;
        pos_in  = tbl[i].pos;
        ack     = tbl[i].ack;
        ovf_clr = tbl[i].oclr;
        x.idx = i; x.vec = tbl[i].e_vec; x.vld = tbl[i].e_vld;
        x.err = tbl[i].e_err; x.ovf = tbl[i].e_ovf;
        sb.push_back(x);
    endtask

    // Outputs from the edge after a vector is driven are compared on the following falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk($sformatf("v%0d pend_vec", got.idx), 32'(pend_vec), 32'(got.vec));
            chk($sformatf("v%0d pend_vld", got.idx), 32'(pend_vld), 32'(got.vld));
            chk($sformatf("v%0d ack_err",  got.idx), 32'(ack_err),  32'(got.err));
            chk($sformatf("v%0d ovf_cnt",  got.idx), 32'(ovf_cnt),  32'(got.ovf));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_in = 4'h0; mask = 4'hF; pos_in = 2'd0;
        ack = 1'b0; ovf_clr = 1'b0; req_l = 4'h0; clr_l = 1'b0;

        //               req   mask  pos  ack   oclr  vec   vld   err   ovf
        tbl[0]  = mk(4'hA, 4'hF, 2'd0, 1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 16'h0000);
        tbl[1]  = mk(4'h0, 4'hF, 2'd1, 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 16'h0000);
        tbl[2]  = mk(4'h0, 4'hF, 2'd3, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        tbl[3]  = mk(4'h0, 4'hF, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000);
        tbl[4]  = mk(4'h0, 4'hF, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        tbl[5]  = mk(4'h4, 4'hF, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 16'h0000);
        tbl[6]  = mk(4'h4, 4'hF, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 16'h0000);
        tbl[7]  = mk(4'h4, 4'hF, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 16'h0000);
        tbl[8]  = mk(4'h4, 4'hF, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 16'h0000);
        tbl[9]  = mk(4'h4, 4'hF, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 16'h0000);
        tbl[10] = mk(4'h0, 4'hF, 2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        tbl[11] = mk(4'h1, 4'hF, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0000);
        tbl[12] = mk(4'h0, 4'hF, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0000);
        tbl[13] = mk(4'h1, 4'hF, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0001);
        tbl[14] = mk(4'h0, 4'hF, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0001);
        tbl[15] = mk(4'h1, 4'hF, 2'd0, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0001);
        tbl[16] = mk(4'h0, 4'hE, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0001);
        tbl[17] = mk(4'h0, 4'hE, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0001);
        tbl[18] = mk(4'h0, 4'hF, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0001);
        tbl[19] = mk(4'h1, 4'hE, 2'd0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0002);
        tbl[20] = mk(4'h0, 4'hF, 2'd0, 1'b0, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0002);
        tbl[21] = mk(4'h8, 4'hF, 2'd0, 1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 16'h0002);
        tbl[22] = mk(4'h0, 4'hF, 2'd3, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 16'h0002);
        tbl[23] = mk(4'h1, 4'hF, 2'd0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 16'h0000);
        tbl[24] = mk(4'h0, 4'hF, 2'd0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        tbl[25] = mk(4'h4, 4'hF, 2'd0, 1'b0, 1'b0, 4'h4, 1'b1, 1'b0, 16'h0000);
        tbl[26] = mk(4'h0, 4'hF, 2'd1, 1'b1, 1'b0, 4'h4, 1'b1, 1'b1, 16'h0000);
        tbl[27] = mk(4'h0, 4'hF, 2'd2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000);
        tbl[28] = mk(4'h6, 4'hF, 2'd0, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 16'h0000);
        tbl[29] = mk(4'h0, 4'hF, 2'd0, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 16'h0000);
        tbl[30] = mk(4'h6, 4'hF, 2'd0, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0, 16'h0110);
        tbl[31] = mk(4'h0, 4'hF, 2'd0, 1'b1, 1'b0, 4'h6, 1'b1, 1'b1, 16'h0110);

        repeat (3) @(negedge clk);
        chk("reset pend_vec", 32'(pend_vec), 32'h0);
        chk("reset pend_vld", 32'(pend_vld), 32'h0);
        chk("reset ack_err",  32'(ack_err),  32'h0);
        chk("reset ovf_cnt",  32'(ovf_cnt),  32'h0);
        chk("reset lvl vec",  32'(vec_l4),   32'h0);
        chk("reset lvl ovf",  32'(ovf_l2),   32'h0);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            apply(i);
        for (int k = 0; k < 5 && sb.size() != 0; k++)
            @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);

        // Level mode: a held line re-fires every cycle once its bit is pending.
        @(negedge clk);
        #1 req_l = 4'h4;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("lvl w4 cnt2 c%0d", k), 32'(ovf_l4[11:8]), 32'(k - 1));
            chk($sformatf("lvl w2 cnt2 c%0d", k), 32'(ovf_l2[5:4]), 32'((k - 1) > 3 ? 3 : (k - 1)));
        end
        chk("lvl pend_vec", 32'(vec_l4), 32'h4);
        #1 clr_l = 1'b1;
        @(negedge clk);
        chk("lvl w4 clear", 32'(ovf_l4), 32'h0);
        chk("lvl w2 clear", 32'(ovf_l2), 32'h0);
        #1 clr_l = 1'b0;
        req_l = 4'h0;

        // Asynchronous reset between clock edges with state loaded.
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async pend_vec", 32'(pend_vec), 32'h0);
        chk("async pend_vld", 32'(pend_vld), 32'h0);
        chk("async ack_err",  32'(ack_err),  32'h0);
        chk("async ovf_cnt",  32'(ovf_cnt),  32'h0);
        chk("async lvl vec",  32'(vec_l4),   32'h0);
        req_in = 4'h1;
        ack    = 1'b0;

        // Line held high across reset release gives exactly one event.
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release pend_vec", 32'(pend_vec), 32'h1);
        chk("release pend_vld", 32'(pend_vld), 32'h1);
        chk("release ovf_cnt",  32'(ovf_cnt),  32'h0);
        @(negedge clk);
        chk("held pend_vec", 32'(pend_vec), 32'h1);
        chk("held ovf_cnt",  32'(ovf_cnt),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
